mem_ctrl: RTL and testbench

- Memory-side controller between the cache controller (upstream) and the block-wide main memory array (downstream).
- Accepts block read/write requests over a valid/ready handshake.
- Models main-memory access latency with counters.
- Absorbs dirty-block evictions in a small in-order write-back buffer that drains to memory in the background, so cache refills are not stalled behind writes.

---
 rtl/mem_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-side controller between the cache controller and the
// block-wide main memory. Reads are serviced one at a time with a modelled
// access latency. Evictions are absorbed into an in-order write-back buffer
// that drains to memory whenever the controller would otherwise sit idle.
// Optional feature macro: MEM_CTRL_WB_FORWARD_EN. When it is defined, a read
// that hits the write-back buffer is answered from the newest matching entry.
module mem_ctrl #(
  parameter int WB_DEPTH  = 4,
  parameter int RD_LAT    = 4,
  parameter int WR_LAT    = 4,
  parameter int PA_WIDTH  = 32,
  parameter int BLK_WIDTH = 512,
  parameter int BYTE      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [PA_WIDTH-1:0]           req_addr,
  input  logic [BLK_WIDTH-1:0]          req_wdata,
  output logic                          resp_valid,
  output logic [BLK_WIDTH-1:0]          resp_rdata,
  output logic [PA_WIDTH-1:0]           mem_addr,
  output logic                          mem_rd_en,
  output logic                          mem_wr_en,
  output logic [BLK_WIDTH-1:0]          mem_wr_data,
  input  logic [BLK_WIDTH-1:0]          mem_rd_data,
  output logic [$clog2(WB_DEPTH+1)-1:0] wb_count,
  output logic                          busy
);

  localparam int OFF_W   = $clog2(BLK_WIDTH / BYTE);
  localparam int PW      = $clog2(WB_DEPTH);
  localparam int CW      = $clog2(WB_DEPTH + 1);
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CW-1:0]       DEPTH_C  = CW'(WB_DEPTH);
  localparam logic [CNT_W-1:0]    RD_LOAD  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]    WR_LOAD  = CNT_W'(WR_LAT - 1);
  localparam logic [PA_WIDTH-1:0] OFF_MASK = PA_WIDTH'((64'd1 << OFF_W) - 64'd1);

`ifdef MEM_CTRL_WB_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  // Block offset bits never reach memory or the buffer.
  function automatic logic [PA_WIDTH-1:0] align_addr(input logic [PA_WIDTH-1:0] a);
    return a & ~OFF_MASK;
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [BLK_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [PA_WIDTH-1:0]  rd_addr_q, rd_addr_d;

  logic [PA_WIDTH-1:0]  wb_addr_q [WB_DEPTH];
  logic [BLK_WIDTH-1:0] wb_data_q [WB_DEPTH];

  logic [PA_WIDTH-1:0]  req_aligned;
  logic                 hit;
  logic [BLK_WIDTH-1:0] hit_data;
  logic                 wr_ready, rd_ready;
  logic                 wr_acc, rd_acc;
  logic                 pop;

  // Scan valid buffer entries oldest to newest; the last match is the newest copy.
  always_comb begin
    req_aligned = align_addr(req_addr);
    hit         = 1'b0;
    hit_data    = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if ((CW'(k) < count_q) && (wb_addr_q[head_q + PW'(k)] == req_aligned)) begin
        hit      = 1'b1;
        hit_data = wb_data_q[head_q + PW'(k)];
      end
    end
  end

  assign wr_ready  = (count_q < DEPTH_C);
  assign rd_ready  = (state_q == IDLE) && (FWD_EN || !hit);
  assign req_ready = rst_n && (req_we ? wr_ready : rd_ready);
  assign wr_acc    = req_valid && req_we && wr_ready;
  assign rd_acc    = req_valid && !req_we && rd_ready;

  // Next-state and memory-side outputs; reads take priority over draining.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_addr_d    = rd_addr_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    pop          = 1'b0;
    mem_addr     = '0;
    mem_wr_data  = '0;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_acc) begin
          if (FWD_EN && hit) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = hit_data;
          end else begin
            state_d   = RD;
            cnt_d     = RD_LOAD;
            rd_addr_d = req_aligned;
          end
        end else if (count_q != '0) begin
          state_d = WR;
          cnt_d   = WR_LOAD;
        end
      end
      RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = rd_addr_q;
        if (cnt_q == '0) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_rd_data;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR: begin
        mem_addr    = wb_addr_q[head_q];
        mem_wr_data = wb_data_q[head_q];
        if (cnt_q == '0) begin
          mem_wr_en = 1'b1;
          pop       = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer pointer and occupancy bookkeeping; pointers wrap naturally.
  always_comb begin
    head_d  = pop ? head_q + PW'(1) : head_q;
    tail_d  = wr_acc ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset aborts any access in flight and empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Payload storage; only ever observed through state-qualified paths.
  always_ff @(posedge clk) begin
    rd_addr_q <= rd_addr_d;
    if (wr_acc) begin
      wb_addr_q[tail_q] <= req_aligned;
      wb_data_q[tail_q] <= req_wdata;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign wb_count   = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl. The reference model treats the
// controller as a coherent block store: a read returns the last value written
// to that block, evictions reach memory in acceptance order.
`timescale 1ns/1ps
module tb_mem_ctrl;
  localparam int WB_DEPTH  = 4;
  localparam int RD_LAT    = 4;
  localparam int WR_LAT    = 4;
  localparam int PA_WIDTH  = 32;
  localparam int BLK_WIDTH = 512;
  localparam int CW        = $clog2(WB_DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic                 req_we = 1'b0;
  logic [PA_WIDTH-1:0]  req_addr = '0;
  logic [BLK_WIDTH-1:0] req_wdata = '0;
  logic                 resp_valid;
  logic [BLK_WIDTH-1:0] resp_rdata;
  logic [PA_WIDTH-1:0]  mem_addr;
  logic                 mem_rd_en;
  logic                 mem_wr_en;
  logic [BLK_WIDTH-1:0] mem_wr_data;
  logic [BLK_WIDTH-1:0] mem_rd_data;
  logic [CW-1:0]        wb_count;
  logic                 busy;

  mem_ctrl #(.WB_DEPTH(WB_DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT),
             .PA_WIDTH(PA_WIDTH), .BLK_WIDTH(BLK_WIDTH), .BYTE(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .wb_count(wb_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] a; logic [BLK_WIDTH-1:0] d; } ent_t;
  typedef struct packed { logic [BLK_WIDTH-1:0] d; int acc; int lat; } rexp_t;

  logic [BLK_WIDTH-1:0] tbmem   [256];
  logic [BLK_WIDTH-1:0] ref_mem [256];
  logic [BLK_WIDTH-1:0] latest  [256];
  ent_t  pend [$];
  rexp_t rexp [$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int rd_cycles = 0;
  int wr_pulses = 0;
  int last_wr_cyc = -1;
  int last_resp_cyc = -1;

  assign mem_rd_data = tbmem[mem_addr[13:6]];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BLK_WIDTH-1:0] init_val(input int i);
    if (i == 1) return {64{8'hA5}};
    return {64{8'h5A}} ^ BLK_WIDTH'(i);
  endfunction

  function automatic logic [BLK_WIDTH-1:0] rnd_blk();
    logic [BLK_WIDTH-1:0] v;
    for (int i = 0; i < BLK_WIDTH / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic bit pend_hit(input logic [31:0] aa);
    foreach (pend[i]) if (pend[i].a == aa) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [BLK_WIDTH-1:0] act,
                         input logic [BLK_WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Memory array: combinational read, write on the enable pulse.
  initial begin
    for (int i = 0; i < 256; i++) tbmem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_wr_en) tbmem[mem_addr[13:6]] <= mem_wr_data;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a drain or a response.
  initial begin
    ent_t  e;
    rexp_t r;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk_int("wb_count", int'(wb_count), pend.size());
        chk_int("rd_wr_exclusive", int'(mem_rd_en & mem_wr_en), 0);
        if (mem_rd_en) rd_cycles++;
        if (mem_wr_en) begin
          if (pend.size() == 0) begin
            chk_int("unexpected_drain", 1, 0);
          end else begin
            e = pend.pop_front();
            chk_int("drain_addr", int'(mem_addr), int'(e.a));
            chk_blk("drain_data", mem_wr_data, e.d);
            ref_mem[e.a[13:6]] = e.d;
          end
          wr_pulses++;
          last_wr_cyc = cyc;
        end
        if (resp_valid) begin
          if (rexp.size() == 0) begin
            chk_int("unexpected_resp", 1, 0);
          end else begin
            r = rexp.pop_front();
            chk_blk("resp_data", resp_rdata, r.d);
            chk_int("resp_latency", cyc - r.acc, r.lat);
          end
          last_resp_cyc = cyc;
        end
      end
    end
  end

  // Present one request until accepted; entered and left just after a rising edge.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [BLK_WIDTH-1:0] data, output int acc);
    ent_t  e;
    rexp_t r;
    bit    done;
    int    blk;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    done      = 1'b0;
    acc       = -1;
    blk       = int'(addr[13:6]);
    for (int n = 0; n < 300 && !done; n++) begin
      #1;
      if (req_ready) begin
        acc = cyc;
        if (we) begin
          latest[blk] = data;
        end else begin
          r.d   = latest[blk];
          r.acc = cyc;
`ifdef MEM_CTRL_WB_FORWARD_EN
          r.lat = pend_hit({addr[31:6], 6'b0}) ? 1 : RD_LAT + 1;
`else
          r.lat = RD_LAT + 1;
`endif
          rexp.push_back(r);
        end
        @(posedge clk);
        if (we) begin
          e.a = {addr[31:6], 6'b0};
          e.d = data;
          pend.push_back(e);
        end
        done = 1'b1;
      end else begin
        @(posedge clk);
      end
      #1;
    end
    if (!done) chk_int("accept_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || rexp.size() != 0) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) chk_int("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag, input bit with_ready);
    if (with_ready) chk_int({tag, "_req_ready"}, int'(req_ready), 0);
    chk_int({tag, "_resp_valid"}, int'(resp_valid), 0);
    chk_int({tag, "_resp_rdata"}, int'(|resp_rdata), 0);
    chk_int({tag, "_mem_addr"}, int'(|mem_addr), 0);
    chk_int({tag, "_mem_rd_en"}, int'(mem_rd_en), 0);
    chk_int({tag, "_mem_wr_en"}, int'(mem_wr_en), 0);
    chk_int({tag, "_mem_wr_data"}, int'(|mem_wr_data), 0);
    chk_int({tag, "_wb_count"}, int'(wb_count), 0);
    chk_int({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int a1, a2, a3, a4, a5, w, r, rd0, wp0, mism, sel;
    logic [BLK_WIDTH-1:0] d1, d2;
    logic [31:0] ra;
    for (int i = 0; i < 256; i++) latest[i] = init_val(i);

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("in_reset", 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_outputs_zero("after_reset", 1'b0);

    // First read of a preloaded block
    rd0 = rd_cycles;
    issue(1'b0, 32'h040, '0, r);
    wait_idle();
    chk_int("first_read_rd_cycles", rd_cycles - rd0, RD_LAT);
    chk_blk("first_read_data", resp_rdata, {64{8'hA5}});

    // Fill the buffer past capacity
    issue(1'b1, 32'h000, rnd_blk(), a1);
    issue(1'b1, 32'h040, rnd_blk(), a2);
    issue(1'b1, 32'h080, rnd_blk(), a3);
    issue(1'b1, 32'h0C0, rnd_blk(), a4);
    chk_int("fill_count4", int'(wb_count), 4);
    chk_int("fill_burst", a4 - a1, 3);
    issue(1'b1, 32'h100, rnd_blk(), a5);
    chk_int("fill_5th_stall", a5, last_wr_cyc + 1);
    wait_idle();
    for (int i = 0; i < 5; i++) chk_blk("fill_mem", tbmem[i], latest[i]);

    // Read beats pending drain
    issue(1'b1, 32'h200, rnd_blk(), w);
    issue(1'b0, 32'h300, '0, r);
    chk_int("prio_read_accept", r, w + 1);
    wait_idle();
    chk_int("prio_drain_after_resp", last_wr_cyc, last_resp_cyc + WR_LAT);

    // Read hazard on a buffered block
    d1 = rnd_blk();
    rd0 = rd_cycles;
    issue(1'b1, 32'h080, d1, w);
    issue(1'b0, 32'h080, '0, r);
`ifdef MEM_CTRL_WB_FORWARD_EN
    chk_int("hazard_accept", r, w + 1);
`else
    chk_int("hazard_accept", r, last_wr_cyc + 1);
`endif
    wait_idle();
`ifdef MEM_CTRL_WB_FORWARD_EN
    chk_int("hazard_rd_cycles", rd_cycles - rd0, 0);
`else
    chk_int("hazard_rd_cycles", rd_cycles - rd0, RD_LAT);
`endif
    chk_blk("hazard_data", resp_rdata, d1);

    // Duplicate addresses in the buffer
    d1 = rnd_blk();
    d2 = rnd_blk();
    issue(1'b1, 32'h0C4, d1, w);
    issue(1'b1, 32'h0C0, d2, w);
    issue(1'b0, 32'h0C8, '0, r);
    wait_idle();
    chk_blk("dup_resp", resp_rdata, d2);
    chk_blk("dup_mem", tbmem[3], d2);

    // Random traffic
    for (int it = 0; it < 300; it++) begin
      sel = $urandom_range(0, 9);
      ra  = (32'($urandom_range(0, 15)) << 6) | 32'($urandom_range(0, 63));
      if (sel < 4) issue(1'b1, ra, rnd_blk(), w);
      else if (sel < 8) issue(1'b0, ra, '0, r);
      else begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();

    // Reset during the second cycle of a drain
    issue(1'b1, 32'h100, rnd_blk(), w);
    issue(1'b1, 32'h140, rnd_blk(), w);
    issue(1'b1, 32'h180, rnd_blk(), w);
    chk_int("abort_count3", int'(wb_count), 3);
    chk_int("abort_draining", int'(mem_addr), 32'h100);
    wp0 = wr_pulses;
    rst_n = 1'b0;
    pend.delete();
    rexp.delete();
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("abort_reset", 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) latest[i] = ref_mem[i];
    repeat (8) @(posedge clk);
    #1;
    chk_int("abort_no_write", wr_pulses - wp0, 0);
    chk_int("abort_wb_count", int'(wb_count), 0);
    chk_int("abort_idle", int'(busy), 0);

    // A read after the abort sees pre-abort memory contents
    issue(1'b0, 32'h140, '0, r);
    wait_idle();

    mism = 0;
    for (int i = 0; i < 256; i++) if (tbmem[i] !== ref_mem[i]) mism++;
    chk_int("final_memory", mism, 0);
    chk_int("final_pending", pend.size(), 0);
    chk_int("final_resp_queue", rexp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule
